// File: rtl/io_port.sv
// General-purpose I/O port: TRIS direction register, PORT output latch, pin synchroniser
// and interrupt-on-change detection on a configurable subset of bits.
module io_port #(
  parameter int unsigned      WIDTH       = 5,
  parameter logic [WIDTH-1:0] TRIS_RESET  = '1,
  parameter logic [WIDTH-1:0] IOC_MASK    = '0,
  parameter int unsigned      SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tris_we,
  input  logic             port_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             port_rd,
  input  logic             ioc_clr,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] tris_val,
  output logic [WIDTH-1:0] port_rdata,
  output logic             ioc_flag
);

  logic [WIDTH-1:0] tris_q;
  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] snap_q;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic             flag_q;
  logic             flag_d;
  logic [WIDTH-1:0] sync;
  logic             mismatch;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      tris_q  <= TRIS_RESET;
      latch_q <= '0;
      snap_q  <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      if (tris_we) tris_q <= wdata;
      if (port_we) latch_q <= wdata;
      if (port_rd) snap_q <= sync;
      sync_q[0] <= pin_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  // Compare against the pre-update snapshot so a read in a mismatch cycle still sets the flag.
  assign mismatch = |((sync ^ snap_q) & IOC_MASK & tris_q);

  always_comb begin
    flag_d = flag_q;
    if (mismatch) begin
      flag_d = 1'b1;
    end else if (ioc_clr) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign tris_val   = tris_q;
  assign pin_oe     = ~tris_q;
  assign pin_out    = latch_q;
  assign port_rdata = (tris_q & sync) | (~tris_q & latch_q);
  assign ioc_flag   = flag_q;

endmodule
